shake256_squeeze_reader: RTL and testbench

//  Output-side consumer of the SHAKE256 core. Captures each 1088-bit rate block presented on

---
 rtl/shake_pkg.sv | 24 ++
 rtl/shake_block_fifo2.sv | 66 ++++++
 rtl/shake256_squeeze_reader.sv | 140 ++++++++++++++
 tb/tb_shake256_squeeze_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// ============================================================================
// Module      : shake_pkg
// Description : Shared constants and state type for the SHAKE256 squeeze reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shake_pkg;
    localparam int RATE_BITS       = 1088;
    localparam int RATE_BYTES      = RATE_BITS / 8;
    localparam int WORD_W          = 64;
    localparam int WORD_BYTES      = WORD_W / 8;
    localparam int WORDS_PER_BLOCK = RATE_BITS / WORD_W;
    localparam int LEN_W           = 16;
    localparam int WIDX_W          = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ZERO   = 2'd2
    } sqz_state_t;
endpackage

`default_nettype wire

// File: rtl/shake_block_fifo2.sv
// ============================================================================
// Module      : shake_block_fifo2
// Description : Two-entry rate-block buffer; push while full is accepted only
//               together with a pop. Flush drops all held blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shake_block_fifo2
    import shake_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [RATE_BITS-1:0] wr_block_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [RATE_BITS-1:0] rd_block_o
);
    logic [RATE_BITS-1:0] mem_q [2];
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;
    logic [1:0]           count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o     = (count_q == 2'd2);
    assign empty_o    = (count_q == 2'd0);
    assign rd_block_o = mem_q[rd_q];

    always_comb begin
        do_push = push_i && (!full_o || pop_i) && !flush_i;
        do_pop  = pop_i && !empty_o && !flush_i;
        count_d = count_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (flush_i) begin
            count_d = 2'd0;
            rd_d    = wr_q;
        end else begin
            if (do_push) wr_d = ~wr_q;
            if (do_pop)  rd_d = ~rd_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: it is only read while count is non-zero.
    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_q] <= wr_block_i;
    end
endmodule

`default_nettype wire

// File: rtl/shake256_squeeze_reader.sv
// ============================================================================
// Module      : shake256_squeeze_reader
// Description : Captures SHAKE256 rate blocks and serialises the requested
//               byte count as MSB-first 64-bit beats on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shake256_squeeze_reader
    import shake_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      out_len_i,
    input  logic                  squeezed_i,
    input  logic [RATE_BITS-1:0]  hash_i,
    output logic [WORD_W-1:0]     out_data_o,
    output logic [WORD_BYTES-1:0] out_keep_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overrun_o
);
    sqz_state_t           state_q, state_d;
    logic                 squeezed_q;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [WIDX_W-1:0]    widx_q, widx_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    logic                 cap, hs, last;
    logic                 push, pop, flush, full, empty;
    logic [RATE_BITS-1:0] rd_block;
    logic [WORD_W-1:0]    word, mask;
    logic [WORD_BYTES-1:0] keep;
    logic [WORD_BYTES-1:0] keep_all;

    shake_block_fifo2 u_fifo (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .flush_i    (flush),
        .push_i     (push),
        .pop_i      (pop),
        .wr_block_i (hash_i),
        .full_o     (full),
        .empty_o    (empty),
        .rd_block_o (rd_block)
    );

    assign cap      = squeezed_i & ~squeezed_q;
    assign keep_all = '1;
    assign last     = (rem_q <= LEN_W'(WORD_BYTES));
    assign keep     = last ? ~(keep_all >> rem_q) : keep_all;
    assign word     = rd_block[(WORDS_PER_BLOCK-1-int'(widx_q))*WORD_W +: WORD_W];

    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_mask
        assign mask[i*8 +: 8] = {8{keep[i]}};
    end

    assign out_valid_o = (state_q == STREAM) && !empty;
    assign hs          = out_valid_o && out_ready_i;
    assign out_data_o  = out_valid_o ? (word & mask) : '0;
    assign out_keep_o  = out_valid_o ? keep : '0;
    assign out_last_o  = out_valid_o && last;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign overrun_o   = overrun_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        widx_d    = widx_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    overrun_d = 1'b0;
                    flush     = 1'b1;
                    rem_d     = out_len_i;
                    widx_d    = '0;
                    state_d   = (out_len_i == '0) ? ZERO : STREAM;
                end
            end
            ZERO: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            STREAM: begin
                if (hs) begin
                    rem_d  = last ? '0 : rem_q - LEN_W'(WORD_BYTES);
                    widx_d = widx_q + 1'b1;
                    if (widx_q == WIDX_W'(WORDS_PER_BLOCK-1) || last) begin
                        pop    = 1'b1;
                        widx_d = '0;
                    end
                end
                if (cap) begin
                    if (!full || pop) push = 1'b1;
                    else              overrun_d = 1'b1;
                end
                // Completing the request discards anything still buffered.
                if (hs && last) begin
                    flush   = 1'b1;
                    push    = 1'b0;
                    pop     = 1'b0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            squeezed_q <= 1'b0;
            rem_q      <= '0;
            widx_q     <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            squeezed_q <= squeezed_i;
            rem_q      <= rem_d;
            widx_q     <= widx_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_shake256_squeeze_reader.sv
// ============================================================================
// Module      : tb_shake256_squeeze_reader
// Description : Self-checking bench with a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shake256_squeeze_reader;
    import shake_pkg::*;

    typedef logic [RATE_BITS-1:0] blk_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        squeezed = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_len = '0;
    blk_t        hash = '0;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_valid, out_last, busy, done, overrun;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int   m_state = 0;     // 0 idle, 1 streaming, 2 zero-length
    blk_t mq[$];
    int   m_boff = 0;
    int   m_rem = 0;
    bit   m_sqq = 1'b0;
    bit   m_done = 1'b0;
    bit   m_ovr = 1'b0;

    logic [72:0] beat_log[$];   // {last, keep, data} of each transferred beat

    always #5 clock = ~clock;

    shake256_squeeze_reader dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .start_i     (start),
        .out_len_i   (out_len),
        .squeezed_i  (squeezed),
        .hash_i      (hash),
        .out_data_o  (out_data),
        .out_keep_o  (out_keep),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .done_o      (done),
        .overrun_o   (overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < RATE_BITS/32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [63:0] word_of(input blk_t b, input int w);
        return b[RATE_BITS-1-64*w -: 64];
    endfunction

    task automatic compare();
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        ev, el;
        blk_t        h;
        int          n;
        ed = '0; ek = '0; el = 1'b0;
        ev = (m_state == 1) && (mq.size() > 0);
        if (ev) begin
            h  = mq[0];
            n  = (m_rem < 8) ? m_rem : 8;
            el = (m_rem <= 8);
            for (int i = 0; i < 8; i++) begin
                if (i < n) begin
                    ed[63-8*i -: 8] = h[RATE_BITS-1-8*(m_boff+i) -: 8];
                    ek[7-i] = 1'b1;
                end
            end
        end
        check("valid",   64'(out_valid), 64'(ev));
        check("data",    out_data, ed);
        check("keep",    64'(out_keep), 64'(ek));
        check("last",    64'(out_last), 64'(el));
        check("busy",    64'(busy), 64'(m_state != 0));
        check("done",    64'(done), 64'(m_done));
        check("overrun", 64'(overrun), 64'(m_ovr));
        if (out_valid === 1'b1 && out_ready === 1'b1)
            beat_log.push_back({out_last, out_keep, out_data});
    endtask

    task automatic model_step();
        bit cap, hs, last, pop;
        int n;
        if (reset) begin
            m_state = 0; mq.delete(); m_boff = 0; m_rem = 0;
            m_sqq = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
            return;
        end
        cap    = squeezed && !m_sqq;
        m_sqq  = squeezed;
        m_done = 1'b0;
        case (m_state)
            0: if (start) begin
                m_ovr = 1'b0; mq.delete(); m_rem = int'(out_len); m_boff = 0;
                m_state = (out_len == 0) ? 2 : 1;
            end
            2: begin m_state = 0; m_done = 1'b1; end
            default: begin
                hs = (mq.size() > 0) && out_ready; last = (m_rem <= 8); pop = 1'b0;
                if (hs) begin
                    n = (m_rem < 8) ? m_rem : 8;
                    m_rem -= n;
                    m_boff += 8;
                    if (m_boff == RATE_BYTES || last) pop = 1'b1;
                end
                if (pop) begin void'(mq.pop_front()); m_boff = 0; end
                if (cap) begin
                    if (mq.size() < 2) mq.push_back(hash);
                    else m_ovr = 1'b1;
                end
                if (hs && last) begin mq.delete(); m_state = 0; m_done = 1'b1; end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) compare();
            @(posedge clock);
            model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_start(input int len);
        start = 1'b1; out_len = 16'(len);
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_cap(input blk_t b);
        squeezed = 1'b1; hash = b;
        cyc(1);
        squeezed = 1'b0;
        cyc(1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin cyc(1); k++; end
        check(name, 64'(busy), 64'(0));
    endtask

    logic [63:0] s1_words [4];
    blk_t        b0, b1, b2, b3, b4;
    int          dcnt;
    bit          vseen;

    initial begin
        s1_words[0] = 64'h46b9dd2b0ba88d13; s1_words[1] = 64'h233b3feb743eeb24;
        s1_words[2] = 64'h3fcd52ea62b81b82; s1_words[3] = 64'hb50c27646ed5762f;
        b0 = rand_blk();
        b0[RATE_BITS-1 -: 256] = 256'h46b9dd2b0ba88d13233b3feb743eeb243fcd52ea62b81b82b50c27646ed5762f;

        cyc(2);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_busy",  64'(busy), 64'(0));

        // 32-byte request from the empty-message digest
        out_ready = 1'b1; beat_log.delete();
        do_start(32); do_cap(b0); wait_idle("s1_idle", 100);
        check("s1_beats", 64'(beat_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < beat_log.size(); i++) begin
            check("s1_word", beat_log[i][63:0], s1_words[i]);
            check("s1_keep", 64'(beat_log[i][71:64]), 64'hFF);
            check("s1_last", 64'(beat_log[i][72]), 64'(i == 3));
        end

        // 13-byte request: partial final beat
        beat_log.delete();
        do_start(13); do_cap(b0); wait_idle("s2_idle", 100);
        check("s2_beats", 64'(beat_log.size()), 64'(2));
        if (beat_log.size() == 2) begin
            check("s2_w0",   beat_log[0][63:0], 64'h46b9dd2b0ba88d13);
            check("s2_w1",   beat_log[1][63:0], 64'h233b3feb74000000);
            check("s2_keep", 64'(beat_log[1][71:64]), 64'hF8);
            check("s2_last", 64'(beat_log[1][72]), 64'(1));
        end

        // 300 bytes across three blocks
        b1 = rand_blk(); b2 = rand_blk(); b3 = rand_blk();
        beat_log.delete();
        do_start(300);
        do_cap(b1); cyc(10); do_cap(b2); cyc(10); do_cap(b3);
        wait_idle("s3_idle", 200);
        check("s3_beats", 64'(beat_log.size()), 64'(38));
        if (beat_log.size() == 38) begin
            check("s3_b16",  beat_log[16][63:0], word_of(b1, 16));
            check("s3_b17",  beat_log[17][63:0], word_of(b2, 0));
            check("s3_b34",  beat_log[34][63:0], word_of(b3, 0));
            check("s3_keep", 64'(beat_log[37][71:64]), 64'hF0);
            check("s3_last", 64'(beat_log[37][72]), 64'(1));
        end
        check("s3_ovr", 64'(overrun), 64'(0));

        // Stalled downstream: third block overruns
        b4 = rand_blk();
        out_ready = 1'b0; beat_log.delete();
        do_start(300);
        do_cap(b1); cyc(28); do_cap(b2); cyc(28); do_cap(b3);
        check("s4_ovr", 64'(overrun), 64'(1));
        out_ready = 1'b1;
        cyc(45);
        do_cap(b4);
        wait_idle("s4_idle", 100);
        check("s4_beats", 64'(beat_log.size()), 64'(38));
        if (beat_log.size() == 38) begin
            for (int i = 0; i < 34; i++)
                check("s4_word", beat_log[i][63:0], (i < 17) ? word_of(b1, i) : word_of(b2, i-17));
            check("s4_b34", beat_log[34][63:0], word_of(b4, 0));
        end

        // Zero-length request clears overrun and pulses done once
        do_start(0);
        check("s5_ovr_clr", 64'(overrun), 64'(0));
        dcnt = 0; vseen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            dcnt += int'(done);
            vseen |= out_valid;
        end
        check("s5_done_cnt", 64'(dcnt), 64'(1));
        check("s5_no_valid", 64'(vseen), 64'(0));

        // Reset during streaming
        out_ready = 1'b0;
        do_start(300); do_cap(b1); cyc(2);
        check("s6_valid_pre", 64'(out_valid), 64'(1));
        reset = 1'b1; cyc(1); reset = 1'b0;
        check("s6_valid", 64'(out_valid), 64'(0));
        check("s6_busy",  64'(busy), 64'(0));
        check("s6_data",  out_data, 64'(0));
        out_ready = 1'b1;
        do_cap(b2); cyc(3);
        check("s6_ignored", 64'(out_valid), 64'(0));

        // Randomised traffic
        for (int c = 0; c < 5000; c++) begin
            start     = ($urandom_range(0, 15) == 0);
            out_len   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 8))
                                                    : 16'($urandom_range(1, 400));
            squeezed  = (c < 2500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            hash      = rand_blk();
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        start = 1'b0; squeezed = 1'b0; reset = 1'b0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
